// File: rtl/stage_ex_pkg.sv
// ---------------------------------------------------------------------------
// stage_ex_pkg
// Shared definitions for the execute stage of the 3PA five-stage pipeline:
//   - EX/MA pipeline register width and field slices
//   - ALUop codes and forward-select encodings
//   - multiply/divide unit state encoding and an op classification helper
// ---------------------------------------------------------------------------
package stage_ex_pkg;

    // EX/MA register layout, MSB first:
    // {WB[2:0], MA[1:0], ALU_rslt[31:0], Rs2_val[31:0], Rs2_addr[4:0], PC[31:0], Rdst[4:0]}
    localparam int EXMA_WIDTH      = 111;
    localparam int EXMA_WB_HI      = 110;
    localparam int EXMA_WB_LO      = 108;
    localparam int EXMA_MA_HI      = 107;
    localparam int EXMA_MA_LO      = 106;
    localparam int EXMA_ALURSLT_HI = 105;
    localparam int EXMA_ALURSLT_LO = 74;
    localparam int EXMA_RS2VAL_HI  = 73;
    localparam int EXMA_RS2VAL_LO  = 42;
    localparam int EXMA_RS2ADDR_HI = 41;
    localparam int EXMA_RS2ADDR_LO = 37;
    localparam int EXMA_PC_HI      = 36;
    localparam int EXMA_PC_LO      = 5;
    localparam int EXMA_RDS_HI     = 4;
    localparam int EXMA_RDS_LO     = 0;

    // ALUop codes
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;
    localparam logic [3:0] ALU_MUL   = 4'd11;
    localparam logic [3:0] ALU_DIVU  = 4'd12;
    localparam logic [3:0] ALU_REMU  = 4'd13;

    // Forward-select encodings (2'b11 also selects the register file)
    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_EXMA = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_t;

    function automatic logic is_mdu_op(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/stage_ex_mdu.sv
// ---------------------------------------------------------------------------
// mdu_iter
// Iterative multiply / unsigned divide unit, one step per clock.
//   MUL  : shift-add, low 32 bits of the product
//   DIVU : restoring divide, quotient
//   REMU : restoring divide, remainder
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   start     issue request (op is an MDU op and the stage is not flushed)
//   op        ALUop, latched at issue
//   a, b      operands, latched at issue
//   abort     drop the operation in progress (pipeline flush)
//   hold      keep the finished result in DONE (downstream stall)
//   busy      stall request: issuing this cycle or iterating
//   done      result valid this cycle
//   result    MUL / DIVU / REMU result
// ---------------------------------------------------------------------------
module mdu_iter
    import stage_ex_pkg::*;
#(
    parameter int MDU_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        abort,
    input  logic        hold,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int CW = $clog2(MDU_ITER);
    localparam logic [CW-1:0] LAST_ITER = CW'(MDU_ITER - 1);

    mdu_state_t    state_reg;
    logic [CW-1:0] count_reg;
    logic [3:0]    op_reg;
    // MUL: a_reg = shifting multiplicand, lo_reg = shifting multiplier, hi_reg = accumulator
    // DIV: b_reg = divisor, lo_reg = dividend shifting out / quotient shifting in, hi_reg = remainder
    logic [31:0]   a_reg;
    logic [31:0]   b_reg;
    logic [31:0]   hi_reg;
    logic [31:0]   lo_reg;

    logic [32:0]   div_trial;
    logic [32:0]   div_diff;
    logic          div_ge;

    // Restoring step. With a zero divisor every trial succeeds, which leaves an
    // all-ones quotient and shifts the whole dividend into the remainder.
    assign div_trial = {hi_reg, lo_reg[31]};
    assign div_ge    = (div_trial >= {1'b0, b_reg});
    assign div_diff  = div_trial - {1'b0, b_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= MDU_IDLE;
            count_reg <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            case (state_reg)
                MDU_IDLE: begin
                    if (start) begin
                        state_reg <= MDU_BUSY;
                        count_reg <= '0;
                        op_reg    <= op;
                        a_reg     <= a;
                        b_reg     <= b;
                        hi_reg    <= '0;
                        lo_reg    <= (op == ALU_MUL) ? b : a;
                    end
                end
                MDU_BUSY: begin
                    if (abort) begin
                        state_reg <= MDU_IDLE;
                    end else begin
                        if (op_reg == ALU_MUL) begin
                            if (lo_reg[0]) begin
                                hi_reg <= hi_reg + a_reg;
                            end
                            a_reg  <= a_reg << 1;
                            lo_reg <= lo_reg >> 1;
                        end else if (div_ge) begin
                            hi_reg <= div_diff[31:0];
                            lo_reg <= {lo_reg[30:0], 1'b1};
                        end else begin
                            hi_reg <= div_trial[31:0];
                            lo_reg <= {lo_reg[30:0], 1'b0};
                        end
                        count_reg <= count_reg + 1'b1;
                        if (count_reg == LAST_ITER) begin
                            state_reg <= MDU_DONE;
                        end
                    end
                end
                MDU_DONE: begin
                    if (abort || !hold) begin
                        state_reg <= MDU_IDLE;
                    end
                end
                default: state_reg <= MDU_IDLE;
            endcase
        end
    end

    assign busy = (state_reg == MDU_BUSY) || ((state_reg == MDU_IDLE) && start);
    assign done = (state_reg == MDU_DONE);

    always_comb begin
        result = '0;
        case (op_reg)
            ALU_MUL:  result = hi_reg;
            ALU_DIVU: result = lo_reg;
            ALU_REMU: result = hi_reg;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/stage_ex.sv
// ---------------------------------------------------------------------------
// stage_ex
// Execute stage of the 3PA pipeline: operand forwarding, single-cycle ALU,
// iterative multiply/divide, and the EX/MA pipeline register.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   i_ex_WB / i_ex_MA    write-back / memory control, passed through
//   i_ex_EX              {ALUSrc, ALUop[3:0]}
//   i_ex_Rs1_val/Rs2_val register-file operands
//   i_ex_Rs2_addr        Rs2 index, passed through
//   i_ex_imm             sign-extended immediate
//   i_ex_PC, i_ex_Rdst   passed through
//   i_ex_mux_wb          write-back value (forward source)
//   i_ex_fwdA/fwdB       forward selects
//   i_ex_flush           kill EX instruction, abort MDU
//   i_ex_stall           hold EX/MA
//   o_ex_*               registered EX/MA fields
//   o_ex_busy            combinational stall request to upstream stages
// ---------------------------------------------------------------------------
module stage_ex
    import stage_ex_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MDU_ITER = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       i_ex_WB,
    input  logic [1:0]       i_ex_MA,
    input  logic [4:0]       i_ex_EX,
    input  logic [WIDTH-1:0] i_ex_Rs1_val,
    input  logic [WIDTH-1:0] i_ex_Rs2_val,
    input  logic [4:0]       i_ex_Rs2_addr,
    input  logic [WIDTH-1:0] i_ex_imm,
    input  logic [WIDTH-1:0] i_ex_PC,
    input  logic [4:0]       i_ex_Rdst,
    input  logic [WIDTH-1:0] i_ex_mux_wb,
    input  logic [1:0]       i_ex_fwdA,
    input  logic [1:0]       i_ex_fwdB,
    input  logic             i_ex_flush,
    input  logic             i_ex_stall,
    output logic [2:0]       o_ex_WB,
    output logic [1:0]       o_ex_MA,
    output logic [WIDTH-1:0] o_ex_ALU_rslt,
    output logic [WIDTH-1:0] o_ex_Rs2_val,
    output logic [4:0]       o_ex_Rs2_addr,
    output logic [WIDTH-1:0] o_ex_PC,
    output logic [4:0]       o_ex_Rdst,
    output logic             o_ex_busy
);

    logic                  alu_src;
    logic [3:0]            alu_op;
    logic [WIDTH-1:0]      op_a;
    logic [WIDTH-1:0]      op_b_fwd;
    logic [WIDTH-1:0]      op_b;
    logic [WIDTH-1:0]      alu_rslt;
    logic [WIDTH-1:0]      stage_rslt;
    logic                  mdu_start;
    logic                  mdu_busy;
    logic                  mdu_done;
    logic [WIDTH-1:0]      mdu_result;
    logic                  exma_flush;
    logic [EXMA_WIDTH-1:0] exma_reg;
    logic [EXMA_WIDTH-1:0] exma_next;

    assign alu_src = i_ex_EX[4];
    assign alu_op  = i_ex_EX[3:0];

    always_comb begin
        op_a = i_ex_Rs1_val;
        case (i_ex_fwdA)
            FWD_RF:   op_a = i_ex_Rs1_val;
            FWD_EXMA: op_a = o_ex_ALU_rslt;
            FWD_WB:   op_a = i_ex_mux_wb;
            default:  op_a = i_ex_Rs1_val;
        endcase
    end

    always_comb begin
        op_b_fwd = i_ex_Rs2_val;
        case (i_ex_fwdB)
            FWD_RF:   op_b_fwd = i_ex_Rs2_val;
            FWD_EXMA: op_b_fwd = o_ex_ALU_rslt;
            FWD_WB:   op_b_fwd = i_ex_mux_wb;
            default:  op_b_fwd = i_ex_Rs2_val;
        endcase
    end

    // Store data leaves on op_b_fwd; the immediate only feeds the ALU.
    assign op_b = alu_src ? i_ex_imm : op_b_fwd;

    always_comb begin
        alu_rslt = '0;
        case (alu_op)
            ALU_ADD:   alu_rslt = op_a + op_b;
            ALU_SUB:   alu_rslt = op_a - op_b;
            ALU_AND:   alu_rslt = op_a & op_b;
            ALU_OR:    alu_rslt = op_a | op_b;
            ALU_XOR:   alu_rslt = op_a ^ op_b;
            ALU_SLL:   alu_rslt = op_a << op_b[4:0];
            ALU_SRL:   alu_rslt = op_a >> op_b[4:0];
            ALU_SRA:   alu_rslt = $signed(op_a) >>> op_b[4:0];
            ALU_SLT:   alu_rslt = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU:  alu_rslt = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            ALU_PASSB: alu_rslt = op_b;
            default:   alu_rslt = '0;
        endcase
    end

    assign mdu_start = is_mdu_op(alu_op) && !i_ex_flush;

    mdu_iter #(
        .MDU_ITER (MDU_ITER)
    ) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .start  (mdu_start),
        .op     (alu_op),
        .a      (op_a),
        .b      (op_b),
        .abort  (i_ex_flush),
        .hold   (i_ex_stall),
        .busy   (mdu_busy),
        .done   (mdu_done),
        .result (mdu_result)
    );

    assign o_ex_busy  = mdu_busy;
    assign stage_rslt = mdu_done ? mdu_result : alu_rslt;

    assign exma_next = {i_ex_WB, i_ex_MA, stage_rslt, op_b_fwd,
                        i_ex_Rs2_addr, i_ex_PC, i_ex_Rdst};

    // Bubble on flush, or while the MDU is still working and the register is
    // free to advance; a downstream stall otherwise freezes the contents.
    assign exma_flush = i_ex_flush | (o_ex_busy & ~i_ex_stall);

    always_ff @(posedge clk) begin
        if (rst || exma_flush) begin
            exma_reg <= '0;
        end else if (!i_ex_stall) begin
            exma_reg <= exma_next;
        end
    end

    assign o_ex_WB       = exma_reg[EXMA_WB_HI:EXMA_WB_LO];
    assign o_ex_MA       = exma_reg[EXMA_MA_HI:EXMA_MA_LO];
    assign o_ex_ALU_rslt = exma_reg[EXMA_ALURSLT_HI:EXMA_ALURSLT_LO];
    assign o_ex_Rs2_val  = exma_reg[EXMA_RS2VAL_HI:EXMA_RS2VAL_LO];
    assign o_ex_Rs2_addr = exma_reg[EXMA_RS2ADDR_HI:EXMA_RS2ADDR_LO];
    assign o_ex_PC       = exma_reg[EXMA_PC_HI:EXMA_PC_LO];
    assign o_ex_Rdst     = exma_reg[EXMA_RDS_HI:EXMA_RDS_LO];

endmodule
